// File: rtl/btn_count_enable_gen.sv
// Button front end: synchronises and debounces a raw push-button, then turns
// presses into single-cycle count-enable pulses with optional hold/auto-repeat.
module btn_count_enable_gen #(
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic count_enb,
  output logic btn_state,
  output logic repeat_active
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t           state, state_next;
  logic             sync_meta, btn_sync;
  logic [CNT_W-1:0] deb_cnt, fsm_cnt, fsm_cnt_next;
  logic             deb_fire, level_next, pulse_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      btn_sync  <= sync_meta;
    end
  end

  // The debounced level the FSM acts on this edge, so press and release are
  // seen in the same cycle btn_state changes.
  assign deb_fire   = (btn_sync != btn_state) && (deb_cnt == DEB_LAST);
  assign level_next = deb_fire ? btn_sync : btn_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      btn_state <= 1'b0;
    end else if (btn_sync == btn_state) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt   <= '0;
      btn_state <= btn_sync;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    fsm_cnt_next = fsm_cnt + 1'b1;
    pulse_next   = 1'b0;
    case (state)
      IDLE: begin
        fsm_cnt_next = '0;
        if (level_next && !btn_state) begin
          pulse_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!level_next) begin
          state_next   = IDLE;
          fsm_cnt_next = '0;
        end else if (fsm_cnt == HOLD_LAST) begin
          // Without auto-repeat the timer parks here until release.
          if (REPEAT_EN != 0) begin
            pulse_next   = 1'b1;
            state_next   = REPEAT;
            fsm_cnt_next = '0;
          end else begin
            fsm_cnt_next = fsm_cnt;
          end
        end
      end
      REPEAT: begin
        if (!level_next) begin
          state_next   = IDLE;
          fsm_cnt_next = '0;
        end else if (fsm_cnt == REP_LAST) begin
          pulse_next   = 1'b1;
          fsm_cnt_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        fsm_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fsm_cnt       <= '0;
      count_enb     <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state         <= state_next;
      fsm_cnt       <= fsm_cnt_next;
      count_enb     <= pulse_next;
      repeat_active <= (state_next == REPEAT);
    end
  end

endmodule

// File: tb/tb_btn_count_enable_gen.sv
// Directed bench for btn_count_enable_gen with short debounce/hold/repeat
// timings; pulse cycles are logged and compared with hand-computed values.
module tb_btn_count_enable_gen;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic count_enb, btn_state, repeat_active;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int consec       = 0;
  logic prev_enb   = 1'b0;
  int pulse_q[$];

  btn_count_enable_gen #(
    .CNT_W(25), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .count_enb(count_enb), .btn_state(btn_state), .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  // Pulse log sampled just after each rising edge, away from stimulus updates.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (count_enb) pulse_q.push_back(cyc);
    if (count_enb && prev_enb) consec++;
    prev_enb = count_enb;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic val, input int cycles);
    btn_in = val;
    repeat (cycles) @(negedge clk);
  endtask

  int t_press, t_hold, t_col, t_rst;
  logic seen_high;
  int exp_off[6] = '{0, 20, 28, 36, 44, 52};

  initial begin
    reset  = 1'b0;
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_count_enb", count_enb, 0);
    checkOutput("rst_btn_state", btn_state, 0);
    checkOutput("rst_repeat_active", repeat_active, 0);
    checkOutput("rst_no_pulse", pulse_q.size(), 0);
    btn_in = 1'b0;
    reset  = 1'b1;
    applyStimulus(0, 10);
    checkOutput("idle_no_pulse", pulse_q.size(), 0);

    // Clean press, held 15 cycles.
    pulse_q.delete();
    applyStimulus(1, 5);
    checkOutput("press_early_state", btn_state, 0);
    checkOutput("press_early_enb", count_enb, 0);
    applyStimulus(1, 1);
    t_press = cyc;
    checkOutput("press_state", btn_state, 1);
    checkOutput("press_enb", count_enb, 1);
    applyStimulus(1, 1);
    checkOutput("press_enb_drop", count_enb, 0);
    applyStimulus(1, 8);
    applyStimulus(0, 5);
    checkOutput("release_early_state", btn_state, 1);
    applyStimulus(0, 1);
    checkOutput("release_state", btn_state, 0);
    applyStimulus(0, 6);
    checkOutput("press_pulses", pulse_q.size(), 1);
    checkOutput("press_pulse_cyc", pulse_q.size() > 0 ? pulse_q[0] : -1, t_press);

    // Bounce: 2-cycle segments for 20 cycles, then held.
    pulse_q.delete();
    seen_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 2; c++) begin
        applyStimulus((i % 2) == 0, 1);
        seen_high = seen_high | btn_state;
      end
    end
    checkOutput("bounce_state_low", seen_high, 0);
    checkOutput("bounce_no_pulse", pulse_q.size(), 0);
    applyStimulus(1, 5);
    checkOutput("bounce_early_state", btn_state, 0);
    applyStimulus(1, 1);
    t_hold = cyc;
    checkOutput("bounce_state", btn_state, 1);
    checkOutput("bounce_enb", count_enb, 1);

    // Continue holding into auto-repeat; btn_state falls at T+56.
    applyStimulus(1, 19);
    checkOutput("hold_ra_before", repeat_active, 0);
    applyStimulus(1, 1);
    checkOutput("hold_ra_on", repeat_active, 1);
    checkOutput("hold_first_enb", count_enb, 1);
    applyStimulus(1, 30);
    applyStimulus(0, 5);
    checkOutput("hold_ra_late", repeat_active, 1);
    applyStimulus(0, 1);
    checkOutput("hold_release_state", btn_state, 0);
    checkOutput("hold_ra_off", repeat_active, 0);
    applyStimulus(0, 8);
    checkOutput("hold_pulses", pulse_q.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("hold_pulse_%0d", i),
                  i < pulse_q.size() ? pulse_q[i] : -1, t_hold + exp_off[i]);

    // Release landing on the T+36 repeat slot.
    pulse_q.delete();
    applyStimulus(1, 6);
    t_col = cyc;
    checkOutput("col_press_enb", count_enb, 1);
    applyStimulus(1, 30);
    applyStimulus(0, 5);
    checkOutput("col_ra_before", repeat_active, 1);
    applyStimulus(0, 1);
    checkOutput("col_state", btn_state, 0);
    checkOutput("col_no_pulse", count_enb, 0);
    checkOutput("col_ra_off", repeat_active, 0);
    applyStimulus(0, 10);
    checkOutput("col_pulses", pulse_q.size(), 3);
    checkOutput("col_last_pulse", pulse_q.size() == 3 ? pulse_q[2] : -1, t_col + 28);

    // Reset in the middle of REPEAT with the button held.
    applyStimulus(1, 6);
    applyStimulus(1, 24);
    checkOutput("mid_ra", repeat_active, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_enb", count_enb, 0);
    checkOutput("async_state", btn_state, 0);
    checkOutput("async_ra", repeat_active, 0);
    repeat (3) @(negedge clk);
    pulse_q.delete();
    reset = 1'b1;
    applyStimulus(1, 5);
    checkOutput("rerun_early_state", btn_state, 0);
    applyStimulus(1, 1);
    t_rst = cyc;
    checkOutput("rerun_state", btn_state, 1);
    checkOutput("rerun_enb", count_enb, 1);
    applyStimulus(1, 19);
    checkOutput("rerun_no_repeat", pulse_q.size(), 1);
    applyStimulus(1, 1);
    checkOutput("rerun_hold_pulse", pulse_q.size() == 2 ? pulse_q[1] : -1, t_rst + 20);
    applyStimulus(0, 10);

    checkOutput("no_back_to_back", consec, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
